// File: rtl/unconfig_int_add_op32_dp32_if.sv
// Operand/result bundle for the exact pipelined integer adder.
// The master drives the operands; the slave returns the registered sum.
interface unconfig_int_add_op32_dp32_if #(
    parameter int DATA_PATH_BITWIDTH = 32
);
    logic [DATA_PATH_BITWIDTH-1:0] a;
    logic [DATA_PATH_BITWIDTH-1:0] b;
    logic [DATA_PATH_BITWIDTH-1:0] c;

    modport master (
        output a,
        output b,
        input  c
    );

    modport slave (
        input  a,
        input  b,
        output c
    );
endinterface

// File: rtl/unconfig_int_add_op32_dp32.sv
// Exact two-stage pipelined ripple-carry adder, wrap-around sum.
// Reference datapath for the approximate adder family.
module unconfig_int_add_op32_dp32 #(
    parameter int OP_BITWIDTH        = 32,
    parameter int DATA_PATH_BITWIDTH = 32
) (
    input logic                          clk,
    input logic                          rst,
    unconfig_int_add_op32_dp32_if.slave  bus
);
    logic [OP_BITWIDTH-1:0]        op_a;
    logic [OP_BITWIDTH-1:0]        op_b;
    logic [OP_BITWIDTH-1:0]        sum;
    logic [OP_BITWIDTH-1:0]        carry;
    logic [DATA_PATH_BITWIDTH-1:0] c_q;

    assign carry[0] = 1'b0;

    // The carry out of the top cell is dropped, so it is never built.
    for (genvar i = 0; i < OP_BITWIDTH; i++) begin : g_fa
        assign sum[i] = op_a[i] ^ op_b[i] ^ carry[i];
        if (i < OP_BITWIDTH - 1) begin : g_co
            assign carry[i+1] = (op_a[i] & op_b[i])
                              | (carry[i] & (op_a[i] ^ op_b[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            c_q  <= '0;
        end else begin
            op_a <= bus.a[OP_BITWIDTH-1:0];
            op_b <= bus.b[OP_BITWIDTH-1:0];
            c_q  <= DATA_PATH_BITWIDTH'(signed'(sum));
        end
    end

    assign bus.c = c_q;
endmodule

// File: tb/tb_unconfig_int_add_op32_dp32.sv
// Directed and streamed checks for the exact pipelined adder.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_unconfig_int_add_op32_dp32;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    unconfig_int_add_op32_dp32_if #(.DATA_PATH_BITWIDTH(32)) bus ();

    unconfig_int_add_op32_dp32 #(
        .OP_BITWIDTH       (32),
        .DATA_PATH_BITWIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        bus.a = 32'h1234_5678;
        bus.b = 32'h1111_1111;
        #2;
        compared++;
        if (bus.c !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_async c=%h want %h", bus.c, 32'h0);
        end
        step();
        step();
        compared++;
        if (bus.c !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_held c=%h want %h", bus.c, 32'h0);
        end
        bus.a = 32'h0;
        bus.b = 32'h0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        bus.a = 32'd5;
        bus.b = 32'd7;
        step();
        compared++;
        if (bus.c !== 32'h0) begin
            mismatched++;
            $display("FAIL basic_pre c=%h want %h", bus.c, 32'h0);
        end
        bus.a = 32'h0;
        bus.b = 32'h0;
        step();
        compared++;
        if (bus.c !== 32'd12) begin
            mismatched++;
            $display("FAIL basic_add c=%h want %h", bus.c, 32'd12);
        end
    endtask

    task automatic test_vector(input string name,
                               input logic [31:0] va,
                               input logic [31:0] vb,
                               input logic [31:0] want);
        bus.a = va;
        bus.b = vb;
        step();
        step();
        compared++;
        if (bus.c !== want) begin
            mismatched++;
            $display("FAIL %s c=%h want %h", name, bus.c, want);
        end
    endtask

    task automatic test_negative();
        test_vector("neg_minus3_plus1", 32'hFFFF_FFFD, 32'h1, 32'hFFFF_FFFE);
        test_vector("neg_wrap_min", 32'h8000_0000, 32'h8000_0000, 32'h0);
    endtask

    task automatic test_overflow();
        test_vector("ovf_max_plus1", 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        test_vector("ovf_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_vector("carry_chain", 32'h0FFF_FFFF, 32'h1, 32'h1000_0000);
    endtask

    task automatic test_back_to_back();
        logic [31:0] sa [4];
        logic [31:0] sb [4];
        logic [31:0] sw [4];
        sa = '{32'd1, 32'd3, 32'd10, 32'd100};
        sb = '{32'd2, 32'd4, 32'hFFFF_FFF6, 32'd200};
        sw = '{32'd3, 32'd7, 32'd0, 32'd300};
        for (int k = 0; k < 4; k++) begin
            bus.a = sa[k];
            bus.b = sb[k];
            step();
            if (k >= 1) begin
                compared++;
                if (bus.c !== sw[k-1]) begin
                    mismatched++;
                    $display("FAIL stream_%0d c=%h want %h",
                             k - 1, bus.c, sw[k-1]);
                end
            end
        end
        bus.a = 32'h0;
        bus.b = 32'h0;
        step();
        compared++;
        if (bus.c !== sw[3]) begin
            mismatched++;
            $display("FAIL stream_3 c=%h want %h", bus.c, sw[3]);
        end
    endtask

    task automatic test_reset_mid_stream();
        // c holds 300 here; the zero pair is in flight behind it
        bus.a = 32'd50;
        bus.b = 32'd50;
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (bus.c !== 32'h0) begin
            mismatched++;
            $display("FAIL mid_rst_async c=%h want %h", bus.c, 32'h0);
        end
        step();
        step();
        compared++;
        if (bus.c !== 32'h0) begin
            mismatched++;
            $display("FAIL mid_rst_held c=%h want %h", bus.c, 32'h0);
        end
        bus.a = 32'd6;
        bus.b = 32'd6;
        #2;
        rst = 1'b0;
        step();
        compared++;
        if (bus.c !== 32'h0) begin
            mismatched++;
            $display("FAIL mid_rst_stale c=%h want %h", bus.c, 32'h0);
        end
        bus.a = 32'h0;
        bus.b = 32'h0;
        step();
        compared++;
        if (bus.c !== 32'd12) begin
            mismatched++;
            $display("FAIL mid_rst_restart c=%h want %h", bus.c, 32'd12);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra [500];
        logic [31:0] rb [500];
        logic [31:0] want;
        for (int k = 0; k < 500; k++) begin
            ra[k] = $urandom;
            rb[k] = $urandom;
        end
        for (int k = 0; k < 501; k++) begin
            if (k < 500) begin
                bus.a = ra[k];
                bus.b = rb[k];
            end
            step();
            if (k >= 1) begin
                want = ra[k-1] + rb[k-1];
                compared++;
                if (bus.c !== want) begin
                    mismatched++;
                    $display("FAIL random_%0d c=%h want %h",
                             k - 1, bus.c, want);
                end
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.a      = 32'h0;
        bus.b      = 32'h0;
        test_reset();
        test_basic_add();
        test_negative();
        test_overflow();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
